// File: rtl/cpu4_pkg.sv
// cpu4_pkg: opcodes, instruction field positions and FSM states
// shared by the 4-bit processor controller and its register file.
package cpu4_pkg;

  localparam logic [3:0] OP_NOP  = 4'b0000;
  localparam logic [3:0] OP_LDI  = 4'b0001;
  localparam logic [3:0] OP_JMP  = 4'b0010;
  localparam logic [3:0] OP_JZ   = 4'b0011;
  localparam logic [3:0] OP_HALT = 4'b0111;
  localparam logic [1:0] OP_MOV  = 2'b10;
  localparam logic [3:0] OP_ADD  = 4'b1100;
  localparam logic [3:0] OP_SUB  = 4'b1101;
  localparam logic [3:0] OP_AND  = 4'b1110;
  localparam logic [3:0] OP_NOT  = 4'b1111;

  localparam int OPC_HI = 7;
  localparam int OPC_LO = 4;
  localparam int RX_HI  = 3;
  localparam int RX_LO  = 2;
  localparam int RY_HI  = 1;
  localparam int RY_LO  = 0;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_FETCH_IMM,
    S_EXECUTE,
    S_WRITEBACK,
    S_HALT
  } state_t;

endpackage

// File: rtl/cpu4_regfile.sv
// cpu4_regfile: 4x4-bit register file, one sync write port,
// two combinational operand reads and a debug read, async clear.
module cpu4_regfile (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic [1:0] wa,
  input  logic [3:0] wd,
  input  logic [1:0] ra,
  input  logic [1:0] rb,
  input  logic [1:0] dbg_sel,
  output logic [3:0] rda,
  output logic [3:0] rdb,
  output logic [3:0] dbg_data
);

  logic [3:0] mem [4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) mem[i] <= 4'h0;
    end else if (we) begin
      mem[wa] <= wd;
    end
  end

  assign rda      = mem[ra];
  assign rdb      = mem[rb];
  assign dbg_data = mem[dbg_sel];

endmodule

// File: rtl/cpu4_ctrl.sv
// cpu4_ctrl: fetch/decode/sequence controller for the 4-bit CPU.
// Define CPU4_CTRL_JZ_EN to make opcode 0011 a two-word JZ.
module cpu4_ctrl
  import cpu4_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_valid,
  input  logic [7:0]    imem_data,
  output logic [3:0]    alu_rx,
  output logic [3:0]    alu_ry,
  output logic [3:0]    alu_op,
  input  logic [3:0]    alu_out,
  input  logic [1:0]    dbg_sel,
  output logic [3:0]    dbg_data,
  output logic          zero,
  output logic          halted
);

  state_t        state, state_nx;
  logic [AW-1:0] pc;
  logic [7:0]    ir;
  logic [3:0]    opc;
  logic [1:0]    rx, ry;
  logic [3:0]    rd_x, rd_y;
  logic          ex_act, imm_take, imm_jump;
  logic          rf_we;
  logic [3:0]    rf_wd;

  assign opc = ir[OPC_HI:OPC_LO];
  assign rx  = ir[RX_HI:RX_LO];
  assign ry  = ir[RY_HI:RY_LO];

  // reset must silence the request even though state already reads FETCH
  assign imem_req  = rst_n &
                     ((state == S_FETCH) | (state == S_FETCH_IMM));
  assign imem_addr = pc;
  assign halted    = (state == S_HALT);

  assign ex_act = (state == S_EXECUTE) | (state == S_WRITEBACK);
  assign alu_op = ex_act ? opc  : 4'h0;
  assign alu_rx = ex_act ? rd_x : 4'h0;
  assign alu_ry = ex_act ? rd_y : 4'h0;

  assign imm_take = (state == S_FETCH_IMM) & imem_valid;

  always_comb begin
    imm_jump = 1'b0;
    unique case (1'b1)
      opc == OP_JMP: imm_jump = 1'b1;
`ifdef CPU4_CTRL_JZ_EN
      opc == OP_JZ:  imm_jump = zero;
`endif
      default:       imm_jump = 1'b0;
    endcase
  end

  assign rf_we = (state == S_WRITEBACK) |
                 (imm_take & (opc == OP_LDI));
  assign rf_wd = (state == S_WRITEBACK) ? alu_out
                                        : imem_data[3:0];

  always_comb begin
    state_nx = state;
    unique case (state)
      S_FETCH: begin
        if (imem_valid) state_nx = S_DECODE;
      end
      S_DECODE: begin
        unique case (1'b1)
          opc[3:2] == OP_MOV,
          opc == OP_ADD,
          opc == OP_SUB,
          opc == OP_AND,
          opc == OP_NOT:  state_nx = S_EXECUTE;
          opc == OP_LDI,
          opc == OP_JMP:  state_nx = S_FETCH_IMM;
`ifdef CPU4_CTRL_JZ_EN
          opc == OP_JZ:   state_nx = S_FETCH_IMM;
`else
          opc == OP_JZ:   state_nx = S_FETCH;
`endif
          opc == OP_HALT: state_nx = S_HALT;
          opc == OP_NOP:  state_nx = S_FETCH;
          default:        state_nx = S_FETCH;
        endcase
      end
      S_FETCH_IMM: begin
        if (imem_valid) state_nx = S_FETCH;
      end
      S_EXECUTE:   state_nx = S_WRITEBACK;
      S_WRITEBACK: state_nx = S_FETCH;
      S_HALT:      state_nx = S_HALT;
      default:     state_nx = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
      pc    <= '0;
      ir    <= 8'h00;
      zero  <= 1'b0;
    end else begin
      state <= state_nx;
      if ((state == S_FETCH) && imem_valid) begin
        ir <= imem_data;
        pc <= pc + AW'(1);
      end
      if (imm_take) begin
        pc <= imm_jump ? imem_data[AW-1:0] : pc + AW'(1);
      end
      if (state == S_WRITEBACK) zero <= (alu_out == 4'h0);
    end
  end

  cpu4_regfile u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (rf_we),
    .wa       (rx),
    .wd       (rf_wd),
    .ra       (rx),
    .rb       (ry),
    .dbg_sel  (dbg_sel),
    .rda      (rd_x),
    .rdb      (rd_y),
    .dbg_data (dbg_data)
  );

endmodule

// File: tb/tb_cpu4_ctrl.sv
// tb_cpu4_ctrl: instruction-level reference model with per-cycle
// compare, directed programs and randomized memory/wait stimulus.
module tb_cpu4_ctrl;

  localparam int AW = 8;
`ifdef CPU4_CTRL_JZ_EN
  localparam bit JZ_EN = 1'b1;
`else
  localparam bit JZ_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       imem_req;
  logic [7:0] imem_addr;
  logic       imem_valid = 1'b0;
  logic [7:0] imem_data = 8'h00;
  logic [3:0] alu_rx, alu_ry, alu_op, alu_out;
  logic [1:0] dbg_sel = 2'd0;
  logic [3:0] dbg_data;
  logic       zero, halted;

  int total = 0;
  int bad = 0;

  logic [7:0] mem [256];
  logic [7:0] pq [$];
  int         fixed_wait = 0;
  bit         dbg_hold = 1'b0;
  logic [7:0] last_addr = 8'h00;

  always #5 clk = ~clk;

  function automatic logic [3:0] alu_f(input logic [3:0] op,
                                       input logic [3:0] a,
                                       input logic [3:0] b);
    casez (op)
      4'b10??: return b;
      4'b1100: return a + b;
      4'b1101: return a - b;
      4'b1110: return a & b;
      4'b1111: return ~a;
      default: return 4'h0;
    endcase
  endfunction

  assign alu_out = alu_f(alu_op, alu_rx, alu_ry);

  cpu4_ctrl #(.AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_valid (imem_valid),
    .imem_data  (imem_data),
    .alu_rx     (alu_rx),
    .alu_ry     (alu_ry),
    .alu_op     (alu_op),
    .alu_out    (alu_out),
    .dbg_sel    (dbg_sel),
    .dbg_data   (dbg_data),
    .zero       (zero),
    .halted     (halted)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic int pick_wait();
    if (fixed_wait >= 0) return fixed_wait;
    return int'($urandom_range(0, 3));
  endfunction

  // memory: answers a held request after pick_wait() idle cycles
  initial begin : drv
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk);
      #2;
      if (!dbg_hold) dbg_sel = 2'($urandom_range(0, 3));
      if (!rst_n) begin
        imem_valid = 1'b0;
        cnt = pick_wait();
      end else begin
        if (imem_valid) cnt = pick_wait();
        imem_valid = 1'b0;
        if (imem_req) begin
          if (cnt == 0) begin
            imem_valid = 1'b1;
            imem_data  = mem[imem_addr];
          end else begin
            cnt--;
          end
        end
      end
    end
  end

  // reference model: one queue entry per non-fetch cycle
  typedef struct {
    logic [3:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] ri;
    bit         wb;
  } item_t;

  item_t      q [$];
  logic [3:0] m_r [4];
  logic [7:0] m_pc;
  bit         m_zero, m_halt;
  int         imm_kind;
  logic [1:0] imm_ri;

  function automatic item_t mk(input logic [3:0] op, input logic [3:0] a,
                               input logic [3:0] b, input logic [1:0] ri,
                               input bit wb);
    item_t t;
    t.op = op; t.a = a; t.b = b; t.ri = ri; t.wb = wb;
    return t;
  endfunction

  initial begin : cmp
    item_t      it;
    logic [7:0] w;
    logic [3:0] op, wv, va, vb;
    logic [1:0] wi;
    bit         wr, wz;
    q.delete();
    m_pc = 8'h00; m_zero = 1'b0; m_halt = 1'b0; imm_kind = 0;
    imm_ri = 2'd0;
    for (int i = 0; i < 4; i++) m_r[i] = 4'h0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_req", imem_req, 0);
        chk("rst_op", alu_op, 0);
        chk("rst_halted", halted, 0);
        chk("rst_dbg", dbg_data, 0);
        chk("rst_zero", zero, 0);
        q.delete();
        m_pc = 8'h00; m_zero = 1'b0; m_halt = 1'b0; imm_kind = 0;
        for (int i = 0; i < 4; i++) m_r[i] = 4'h0;
      end else begin
        wr = 1'b0; wz = 1'b0; wi = 2'd0; wv = 4'h0;
        chk("dbg", dbg_data, m_r[dbg_sel]);
        chk("zero", zero, m_zero);
        if (q.size() > 0) begin
          it = q.pop_front();
          chk("busy_req", imem_req, 0);
          chk("busy_halted", halted, 0);
          chk("alu_op", alu_op, it.op);
          chk("alu_rx", alu_rx, it.a);
          chk("alu_ry", alu_ry, it.b);
          if (it.wb) begin
            wr = 1'b1; wz = 1'b1; wi = it.ri;
            wv = alu_f(it.op, it.a, it.b);
          end
        end else if (m_halt) begin
          chk("halt_req", imem_req, 0);
          chk("halt_flag", halted, 1);
          chk("halt_op", alu_op, 0);
        end else begin
          chk("fetch_req", imem_req, 1);
          chk("fetch_addr", imem_addr, m_pc);
          chk("fetch_halted", halted, 0);
          chk("fetch_op", alu_op, 0);
          chk("fetch_rx", alu_rx, 0);
          chk("fetch_ry", alu_ry, 0);
          if (imem_valid) begin
            w = mem[m_pc];
            last_addr = imem_addr;
            m_pc = m_pc + 8'd1;
            if (imm_kind != 0) begin
              case (imm_kind)
                1: begin wr = 1'b1; wi = imm_ri; wv = w[3:0]; end
                2: m_pc = w;
                3: if (m_zero) m_pc = w;
                default: ;
              endcase
              imm_kind = 0;
            end else begin
              op = w[7:4];
              va = m_r[w[3:2]];
              vb = m_r[w[1:0]];
              q.push_back(mk(4'h0, 4'h0, 4'h0, 2'd0, 1'b0));
              if (op[3]) begin
                q.push_back(mk(op, va, vb, w[3:2], 1'b0));
                q.push_back(mk(op, va, vb, w[3:2], 1'b1));
              end else if (op == 4'h1) begin
                imm_kind = 1; imm_ri = w[3:2];
              end else if (op == 4'h2) begin
                imm_kind = 2;
              end else if (op == 4'h3 && JZ_EN) begin
                imm_kind = 3;
              end else if (op == 4'h7) begin
                m_halt = 1'b1;
              end
            end
          end
        end
        if (wr) begin
          m_r[wi] = wv;
          if (wz) m_zero = (wv == 4'h0);
        end
      end
    end
  end

  task automatic rst_on();
    @(posedge clk);
    #1 rst_n = 1'b0;
  endtask

  task automatic rst_off();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic load(input logic [7:0] hi_byte);
    foreach (mem[i]) mem[i] = 8'h00;
    for (int i = 0; i < pq.size(); i++) mem[i] = pq[i];
    mem[8'h10] = hi_byte;
  endtask

  task automatic run_halt(input int budget, output int cyc);
    cyc = 0;
    while (!halted && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    chk("halt_reached", halted, 1);
  endtask

  task automatic peek(input string n, input logic [1:0] s,
                      input logic [3:0] e);
    dbg_hold = 1'b1;
    dbg_sel = s;
    #1;
    chk(n, dbg_data, e);
    dbg_hold = 1'b0;
  endtask

  task automatic start(input int wt, input logic [7:0] hb);
    fixed_wait = wt;
    rst_on();
    load(hb);
    rst_off();
  endtask

  initial begin : stim
    int cyc;
    int n;
    logic [7:0] b;
    foreach (mem[i]) mem[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_req", imem_req, 0);
    chk("reset_op", alu_op, 0);

    // LDI R0,5; LDI R1,3; ADD R0,R1; HALT
    pq = '{8'h10, 8'h05, 8'h14, 8'h03, 8'hC1, 8'h70};
    start(0, 8'h00);
    #1;
    chk("first_req", imem_req, 1);
    chk("first_addr", imem_addr, 0);
    run_halt(100, cyc);
    chk("t1_cycles", cyc, 13);
    chk("t1_last_addr", last_addr, 8'h05);
    chk("t1_zero", zero, 0);
    peek("t1_r0", 2'd0, 4'h8);
    peek("t1_r1", 2'd1, 4'h3);

    // same program, three wait cycles per fetch
    start(3, 8'h00);
    run_halt(200, cyc);
    chk("t3_cycles", cyc, 31);
    peek("t3_r0", 2'd0, 4'h8);

    // SUB wraps: 2 - 3 = F
    pq = '{8'h10, 8'h02, 8'h14, 8'h03, 8'hD1, 8'h70};
    start(0, 8'h00);
    run_halt(100, cyc);
    chk("t2_zero0", zero, 0);
    peek("t2_sub", 2'd0, 4'hF);

    // then AND with zero register sets zero flag
    pq = '{8'h10, 8'h02, 8'h14, 8'h03, 8'hD1,
           8'h18, 8'h00, 8'hE2, 8'h70};
    start(0, 8'h00);
    run_halt(100, cyc);
    chk("t2_zero1", zero, 1);
    peek("t2_and", 2'd0, 4'h0);
    peek("t2_r1", 2'd1, 4'h3);

    // JMP FF then NOP at FF wraps to 00
    pq = '{8'h20, 8'hFF};
    start(-1, 8'h00);
    n = 0;
    while (!(imem_req && imem_valid && imem_addr == 8'hFF) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("t4_reach_ff", imem_addr, 8'hFF);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(imem_req && imem_addr != 8'hFF) && n < 60);
    chk("t4_wrap", imem_addr, 8'h00);

    // reset during ADD writeback aborts the write
    pq = '{8'h10, 8'h05, 8'h14, 8'h03, 8'hC1, 8'h70};
    start(0, 8'h00);
    n = 0;
    while (alu_op != 4'hC && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("t5_in_exec", alu_op, 4'hC);
    dbg_hold = 1'b1;
    rst_on();
    #1;
    chk("t5_op", alu_op, 0);
    chk("t5_req", imem_req, 0);
    chk("t5_zero", zero, 0);
    peek("t5_r0", 2'd0, 4'h0);
    peek("t5_r1", 2'd1, 4'h0);
    dbg_hold = 1'b0;
    rst_off();
    #1;
    chk("t5_refetch_req", imem_req, 1);
    chk("t5_refetch_addr", imem_addr, 0);
    run_halt(100, cyc);
    chk("t5_cycles", cyc, 13);
    peek("t5_final_r0", 2'd0, 4'h8);

    // JZ with zero=1
    pq = '{8'h10, 8'h00, 8'hE0, 8'h30, 8'h10, 8'h07, 8'h70};
    start(0, 8'h70);
    run_halt(100, cyc);
    chk("t6_z1_last", last_addr, JZ_EN ? 8'h10 : 8'h06);
    peek("t6_z1_r0", 2'd0, JZ_EN ? 4'h0 : 4'h7);

    // JZ with zero=0 falls through past the immediate
    pq = '{8'h10, 8'h01, 8'hE0, 8'h30, 8'h10, 8'h07, 8'h70};
    start(-1, 8'h70);
    run_halt(200, cyc);
    chk("t6_z0_last", last_addr, 8'h06);
    peek("t6_z0_r0", 2'd0, JZ_EN ? 4'h1 : 4'h7);

    // random programs and memory latency, cut short by reset
    for (int it = 0; it < 25; it++) begin
      fixed_wait = -1;
      rst_on();
      foreach (mem[i]) begin
        b = 8'($urandom);
        if (b[7:4] == 4'h7 && $urandom_range(0, 3) != 0)
          b = {4'hC, b[3:0]};
        mem[i] = b;
      end
      rst_off();
      repeat ($urandom_range(50, 300)) @(negedge clk);
    end

    rst_on();
    rst_off();
    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
